// File: rtl/rat_step_unit.sv
// rat_step_unit
//
// Step/range engine and direction counter for the intelligent-rat maze
// datapath. It picks one coordinate (x or y), steps it by +1 or -1 with
// modulo wrap, and flags steps that leave the grid. It also forms the
// candidate next position. A small registered counter walks the four
// directions, and its all-ones flag (co) tells the controller that every
// direction has been tried.
//
// Build option:
//   RAT_RANGE_CHECK_EN - when defined, out_of_range flags a step off the grid.
//                        When undefined, out_of_range is tied low.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous reset, active low (clears the counter)
//   rst_counter    in   synchronous counter clear (highest priority)
//   ld_counter     in   synchronous counter load
//   inc_counter    in   synchronous counter increment (wraps)
//   counter_ld_val in   value loaded on ld_counter
//   cur_x, cur_y   in   current rat position
//   adder_sel      in   1 = step cur_x, 0 = step cur_y
//   inc_dec_sel    in   0 = +1, 1 = -1
//   x_sel, y_sel   in   1 = take adder_res into next_x / next_y
//   adder_res      out  selected coordinate +/-1 (mod 2^WIDTH)
//   next_x, next_y out  candidate next position
//   out_of_range   out  the step wrapped past a grid edge
//   counter_val    out  direction counter
//   co             out  counter is at all-ones

module rat_step_unit #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rst_counter,
    input  logic                 ld_counter,
    input  logic                 inc_counter,
    input  logic [CNT_WIDTH-1:0] counter_ld_val,
    input  logic [WIDTH-1:0]     cur_x,
    input  logic [WIDTH-1:0]     cur_y,
    input  logic                 adder_sel,
    input  logic                 inc_dec_sel,
    input  logic                 x_sel,
    input  logic                 y_sel,
    output logic [WIDTH-1:0]     adder_res,
    output logic [WIDTH-1:0]     next_x,
    output logic [WIDTH-1:0]     next_y,
    output logic                 out_of_range,
    output logic [CNT_WIDTH-1:0] counter_val,
    output logic                 co
);

    localparam logic [WIDTH-1:0]     ONE_W = WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

    logic [WIDTH-1:0]     adder_inp;
    logic [CNT_WIDTH-1:0] cnt_q;

    assign adder_inp = adder_sel ? cur_x : cur_y;
    assign adder_res = inc_dec_sel ? (adder_inp - ONE_W) : (adder_inp + ONE_W);

    assign next_x = x_sel ? adder_res : cur_x;
    assign next_y = y_sel ? adder_res : cur_y;

`ifdef RAT_RANGE_CHECK_EN
    // A wrapped result is the only way to see 0 after +1 or max after -1.
    assign out_of_range = inc_dec_sel ? (adder_res == '1) : (adder_res == '0);
`else
    assign out_of_range = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (rst_counter) begin
            cnt_q <= '0;
        end else if (ld_counter) begin
            cnt_q <= counter_ld_val;
        end else if (inc_counter) begin
            cnt_q <= cnt_q + ONE_C;
        end
    end

    assign counter_val = cnt_q;
    assign co          = &cnt_q;

endmodule

// File: tb/tb_rat_step_unit.sv
// Self-checking bench for rat_step_unit with scoreboard queues.
module tb_rat_step_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_counter, ld_counter, inc_counter;
    logic [1:0] counter_ld_val;
    logic [3:0] cur_x, cur_y;
    logic       adder_sel, inc_dec_sel, x_sel, y_sel;
    logic [3:0] adder_res, next_x, next_y;
    logic       out_of_range;
    logic [1:0] counter_val;
    logic       co;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] res;
        logic [3:0] nx;
        logic [3:0] ny;
        logic       oor;
    } comb_exp_t;

    comb_exp_t  comb_q[$];
    logic [2:0] cnt_q[$];   // {co, counter_val}
    int         m_cnt;

    rat_step_unit #(.WIDTH(4), .CNT_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .rst_counter(rst_counter), .ld_counter(ld_counter),
        .inc_counter(inc_counter), .counter_ld_val(counter_ld_val),
        .cur_x(cur_x), .cur_y(cur_y),
        .adder_sel(adder_sel), .inc_dec_sel(inc_dec_sel),
        .x_sel(x_sel), .y_sel(y_sel),
        .adder_res(adder_res), .next_x(next_x), .next_y(next_y),
        .out_of_range(out_of_range),
        .counter_val(counter_val), .co(co)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Combinational vector: model result pushed, settled outputs compared.
    task automatic comb_vec(input logic [3:0] x, input logic [3:0] y, input logic asel,
                            input logic ids, input logic xs, input logic ys, input string tag);
        int        inp;
        comb_exp_t e;
        comb_exp_t got;
        cur_x = x; cur_y = y; adder_sel = asel; inc_dec_sel = ids;
        x_sel = xs; y_sel = ys;
        inp   = asel ? int'(x) : int'(y);
        e.res = ids ? 4'((inp + 15) % 16) : 4'((inp + 1) % 16);
        e.nx  = xs ? e.res : x;
        e.ny  = ys ? e.res : y;
`ifdef RAT_RANGE_CHECK_EN
        e.oor = ids ? (inp == 0) : (inp == 15);
`else
        e.oor = 1'b0;
`endif
        comb_q.push_back(e);
        #1;
        chk({tag, "_sb_depth"}, comb_q.size(), 1);
        if (comb_q.size() > 0) begin
            got = comb_q.pop_front();
            chk({tag, "_adder_res"}, adder_res, got.res);
            chk({tag, "_next_x"}, next_x, got.nx);
            chk({tag, "_next_y"}, next_y, got.ny);
            chk({tag, "_oor"}, out_of_range, got.oor);
        end
    endtask

    // One counter cycle: controls driven at negedge, result compared after posedge.
    task automatic cnt_step(input logic rc, input logic ld, input logic [1:0] val,
                            input logic inc, input string tag);
        logic [2:0] e;
        @(negedge clk);
        rst_counter = rc; ld_counter = ld; counter_ld_val = val; inc_counter = inc;
        if (rc)       m_cnt = 0;
        else if (ld)  m_cnt = int'(val);
        else if (inc) m_cnt = (m_cnt + 1) % 4;
        cnt_q.push_back({m_cnt == 3, 2'(m_cnt)});
        @(posedge clk);
        #1;
        rst_counter = 0; ld_counter = 0; inc_counter = 0;
        if (cnt_q.size() > 0) begin
            e = cnt_q.pop_front();
            chk({tag, "_cnt"}, counter_val, e[1:0]);
            chk({tag, "_co"}, co, e[2]);
        end else begin
            chk({tag, "_sb_empty"}, 0, 1);
        end
    endtask

    initial begin
        rst = 1'b0; rst_counter = 0; ld_counter = 0; inc_counter = 0;
        counter_ld_val = 0; cur_x = 0; cur_y = 0; adder_sel = 0;
        inc_dec_sel = 0; x_sel = 0; y_sel = 0;
        m_cnt = 0;
        #2;
        chk("reset_cnt", counter_val, 0);
        chk("reset_co", co, 0);
        @(negedge clk);
        rst = 1'b1;

        // Load 2, then async reset mid-cycle with an increment pending.
        cnt_step(0, 1, 2'd2, 0, "load2");
        inc_counter = 1;
        #1;
        rst = 1'b0;
        #1;
        m_cnt = 0;
        chk("async_rst_cnt", counter_val, 0);
        chk("async_rst_co", co, 0);
        @(posedge clk);
        #1;
        chk("rst_held_cnt", counter_val, 0);
        inc_counter = 0;
        @(negedge clk);
        rst = 1'b1;

        cnt_step(0, 0, 2'd0, 1, "inc1");
        cnt_step(0, 0, 2'd0, 1, "inc2");
        cnt_step(0, 0, 2'd0, 1, "inc3");
        cnt_step(0, 0, 2'd0, 1, "inc_wrap");
        cnt_step(0, 1, 2'd2, 1, "ld_over_inc");
        cnt_step(1, 1, 2'd3, 0, "clr_over_ld");
        cnt_step(0, 1, 2'd3, 0, "load3");
        cnt_step(0, 0, 2'd0, 0, "hold3");
        cnt_step(1, 0, 2'd0, 1, "clr_over_inc");

        // Directed datapath cases.
        comb_vec(4'd5, 4'd9, 1, 0, 1, 0, "x5_inc");
        comb_vec(4'd3, 4'd15, 0, 0, 0, 1, "y15_inc");
        comb_vec(4'd0, 4'd7, 1, 1, 1, 0, "x0_dec");
        comb_vec(4'd1, 4'd7, 1, 1, 1, 1, "x1_dec_both");

        // Sweep every value, both directions, both coordinates.
        for (int v = 0; v < 16; v++) begin
            for (int d = 0; d < 2; d++) begin
                for (int s = 0; s < 2; s++) begin
                    logic [3:0] other;
                    other = 4'($urandom_range(0, 15));
                    comb_vec(s ? 4'(v) : other, s ? other : 4'(v), s[0], d[0],
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "sweep");
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
